// File: rtl/avalon_mem_test_master_if.sv
// Avalon-MM single-port RAM slave bus as seen by the memory test master.
// No waitrequest: every cycle with chipselect asserted is accepted by the slave.
interface avalon_mem_test_master_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   m_address;
   logic [DATA_W/8-1:0] m_byteenable;
   logic                m_chipselect;
   logic                m_write;
   logic [DATA_W-1:0]   m_writedata;
   logic [DATA_W-1:0]   m_readdata;

   modport master (
      output m_address, m_byteenable, m_chipselect, m_write, m_writedata,
      input  m_readdata
   );

   modport slave (
      input  m_address, m_byteenable, m_chipselect, m_write, m_writedata,
      output m_readdata
   );
endinterface

// File: rtl/avalon_mem_test_master.sv
// Memory BIST initiator: writes seed+i over a wrapping word range, reads it back
// one word at a time and reports pass, a saturating error count and the first bad address.
module avalon_mem_test_master #(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic [DATA_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   avalon_mem_test_master_if.master m
);
   typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, FINISH} state_e;

   localparam logic [ADDR_W:0] CNT_ONE  = 1;
   localparam logic [2:0]      LAT_LAST = 3'(READ_LATENCY - 1);

   state_e              state_q, state_d;
   logic [ADDR_W:0]     idx_q, idx_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [DATA_W-1:0]   seed_q, seed_d;
   logic [15:0]         err_q, err_d;
   logic [ADDR_W-1:0]   first_q, first_d;
   logic                seen_q, seen_d;
   logic                pass_q, pass_d;
   logic [2:0]          lat_q, lat_d;

   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_data;
   logic                cs;

   // Address wraps naturally by truncating to ADDR_W bits.
   assign cur_addr = base_q + idx_q[ADDR_W-1:0];
   assign cur_data = seed_q + DATA_W'(idx_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         seed_q  <= '0;
         err_q   <= '0;
         first_q <= '0;
         seen_q  <= 1'b0;
         pass_q  <= 1'b0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         seed_q  <= seed_d;
         err_q   <= err_d;
         first_q <= first_d;
         seen_q  <= seen_d;
         pass_q  <= pass_d;
         lat_q   <= lat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      seed_d  = seed_q;
      err_d   = err_q;
      first_d = first_q;
      seen_d  = seen_q;
      pass_d  = pass_q;
      lat_d   = lat_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = base_addr;
               cnt_d   = word_count;
               seed_d  = seed;
               err_d   = '0;
               first_d = '0;
               seen_d  = 1'b0;
               pass_d  = 1'b0;
               idx_d   = '0;
               state_d = (word_count == '0) ? FINISH : WRITE;
            end
         end
         WRITE: begin
            if (idx_q == cnt_q - CNT_ONE) begin
               idx_d   = '0;
               state_d = RD_ISSUE;
            end else begin
               idx_d = idx_q + CNT_ONE;
            end
         end
         RD_ISSUE: begin
            lat_d   = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (lat_q != LAT_LAST) begin
               lat_d = lat_q + 3'd1;
            end else begin
               if (m.m_readdata != cur_data) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  if (!seen_q) begin
                     seen_d  = 1'b1;
                     first_d = cur_addr;
                  end
               end
               if (idx_q + CNT_ONE == cnt_q) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + CNT_ONE;
                  state_d = RD_ISSUE;
               end
            end
         end
         FINISH: begin
            pass_d  = (err_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // pass is already valid during the done cycle, then held from pass_q.
   always_comb begin
      cs             = (state_q == WRITE) || (state_q == RD_ISSUE);
      busy           = (state_q != IDLE);
      done           = (state_q == FINISH);
      pass           = (state_q == FINISH) ? (err_q == '0) : pass_q;
      err_count      = err_q;
      first_err_addr = first_q;
      m.m_chipselect = cs;
      m.m_write      = (state_q == WRITE);
      m.m_address    = cs ? cur_addr : '0;
      m.m_byteenable = cs ? '1 : '0;
      m.m_writedata  = (state_q == WRITE) ? cur_data : '0;
   end
endmodule
